// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message controller.
// Holds the controller state enum, block geometry and the length-byte helper.
package sha_ctrl_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned BLOCK_BITS  = BLOCK_BYTES * 8;
  localparam int unsigned LEN_OFFSET  = 56;
  localparam int unsigned LEN_WIDTH   = 64;
  localparam int unsigned CNT_WIDTH   = 7;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    FILL,
    PAD80,
    ZERO,
    LEN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Big-endian byte of the bit length for block position 56+idx.
  function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] idx);
    return 8'(len >> {3'(3'd7 - idx), 3'b000});
  endfunction

endpackage

// File: rtl/sha_byte_packer.sv
// 512-bit MSB-first byte shift register with a 0..64 write index.
// Ports: clk, rst (async, active-high), wr/wr_byte (append one byte),
//        clr (zero buffer and index, wins over wr), block, cnt.
module sha_byte_packer
  import sha_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [7:0]            wr_byte,
  input  logic                  clr,
  output logic [BLOCK_BITS-1:0] block,
  output logic [CNT_WIDTH-1:0]  cnt
);

  // Shifting left means the first byte written ends up in bits [511:504].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block <= '0;
      cnt   <= '0;
    end else if (clr) begin
      block <= '0;
      cnt   <= '0;
    end else if (wr) begin
      block <= {block[BLOCK_BITS-9:0], wr_byte};
      cnt   <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sha_msg_controller.sv
// Sequences a SHA-256 core over a byte message: packs bytes into 512-bit
// blocks, applies 0x80 / zero / 64-bit length padding and issues each block
// with a start/done handshake, flagging the first block of each message.
// Ports: clk, rst (async, active-high); byte_in/byte_valid/byte_last/byte_ready
//        (producer side); sha_block/sha_start/sha_init/sha_busy/sha_done
//        (core side); msg_done (final block completed).
module sha_msg_controller
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = sha_ctrl_pkg::LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [BLOCK_BITS-1:0] sha_block,
  output logic                  sha_start,
  output logic                  sha_init,
  input  logic                  sha_busy,
  input  logic                  sha_done,
  output logic                  msg_done
);

  state_t                 state;
  state_t                 ret_state;
  logic                   final_blk;
  logic                   first;
  logic [LEN_WIDTH-1:0]   bit_len;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   pk_wr;
  logic [7:0]             pk_byte;
  logic                   pk_clr;
  logic                   accept;
  logic                   cnt_last;
  logic                   cnt_pre_len;

  assign accept      = byte_valid && byte_ready && (state == FILL);
  assign cnt_last    = (cnt == CNT_WIDTH'(BLOCK_BYTES - 1));
  assign cnt_pre_len = (cnt == CNT_WIDTH'(LEN_OFFSET - 1));

  sha_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .wr      (pk_wr),
    .wr_byte (pk_byte),
    .clr     (pk_clr),
    .block   (sha_block),
    .cnt     (cnt)
  );

  // Byte source for the packer in each writing state.
  always_comb begin
    pk_wr   = 1'b0;
    pk_byte = 8'h00;
    pk_clr  = 1'b0;
    case (state)
      FILL:  begin pk_wr = accept; pk_byte = byte_in; end
      PAD80: begin pk_wr = 1'b1;   pk_byte = PAD_BYTE; end
      ZERO:  begin pk_wr = 1'b1;   pk_byte = 8'h00; end
      LEN:   begin pk_wr = 1'b1;   pk_byte = len_byte(64'(bit_len), cnt[2:0]); end
      WAIT:  pk_clr = sha_done;
      default: ;
    endcase
  end

  // Control FSM; decisions use the index before the current write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      ret_state  <= FILL;
      final_blk  <= 1'b0;
      first      <= 1'b1;
      bit_len    <= '0;
      byte_ready <= 1'b0;
      sha_start  <= 1'b0;
      sha_init   <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      sha_start <= 1'b0;
      msg_done  <= 1'b0;
      case (state)
        FILL: begin
          byte_ready <= 1'b1;
          if (accept) begin
            bit_len <= bit_len + LEN_WIDTH'(8);
            if (cnt_last) begin
              state      <= ISSUE;
              ret_state  <= byte_last ? PAD80 : FILL;
              byte_ready <= 1'b0;
            end else if (byte_last) begin
              state      <= PAD80;
              byte_ready <= 1'b0;
            end
          end
        end
        PAD80: begin
          if (cnt_last) begin
            state     <= ISSUE;
            ret_state <= ZERO;
          end else if (cnt_pre_len) begin
            state <= LEN;
          end else begin
            state <= ZERO;
          end
        end
        ZERO: begin
          if (cnt_last) begin
            state     <= ISSUE;
            ret_state <= ZERO;
          end else if (cnt_pre_len) begin
            state <= LEN;
          end
        end
        LEN: begin
          if (cnt_last) begin
            state     <= ISSUE;
            final_blk <= 1'b1;
          end
        end
        ISSUE: begin
          if (!sha_busy) begin
            sha_start <= 1'b1;
            sha_init  <= first;
            first     <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (sha_done) begin
            if (final_blk) begin
              final_blk <= 1'b0;
              msg_done  <= 1'b1;
              state     <= DONE;
            end else begin
              state      <= ret_state;
              byte_ready <= (ret_state == FILL);
            end
          end
        end
        DONE: begin
          first      <= 1'b1;
          bit_len    <= '0;
          byte_ready <= 1'b1;
          state      <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_controller.sv
// Self-checking bench for sha_msg_controller: a padded-message model builds
// the expected block stream, a per-cycle monitor compares the core handshake.
module tb_sha_msg_controller;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         init;
    logic         fin;
  } exp_t;
  typedef exp_t eq_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_last;
  logic         byte_ready;
  logic [511:0] sha_block;
  logic         sha_start;
  logic         sha_init;
  logic         sha_busy;
  logic         sha_done;
  logic         msg_done;

  int tests = 0;
  int fails = 0;
  exp_t         exp_q[$];
  logic [511:0] cap_blk[$];
  logic         cap_init[$];
  int outstanding = 0;
  int core_epoch  = 0;
  int busy_mode   = 0;
  int core_delay  = 0;
  bit abort       = 1'b0;

  always #5 clk = ~clk;

  sha_msg_controller #(.LEN_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .sha_block  (sha_block),
    .sha_start  (sha_start),
    .sha_init   (sha_init),
    .sha_busy   (sha_busy),
    .sha_done   (sha_done),
    .msg_done   (msg_done)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: pad the whole message, then cut it into 64-byte blocks.
  function automatic eq_t build_blocks(input bq_t m);
    bq_t          p;
    eq_t          q;
    logic [63:0]  bl;
    logic [511:0] blk;
    int           nb;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[63-8*i -: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk = {blk[503:0], p[b*64+j]};
      q.push_back('{blk: blk, init: 1'(b == 0), fin: 1'(b == nb - 1)});
    end
    return q;
  endfunction

  task automatic push_msg(input bq_t m);
    eq_t q;
    q = build_blocks(m);
    foreach (q[i]) exp_q.push_back(q[i]);
    outstanding++;
  endtask

  task automatic send_msg(input bq_t m, input int max_gap);
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < m.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        byte_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_in    = m[i];
      byte_last  = (i == m.size() - 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!byte_ready && !abort && n < 3000);
      if (abort) return;
      if (!byte_ready) begin
        check("byte_accept", byte_ready, 1);
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (outstanding != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 512'(outstanding), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_caps();
    cap_blk.delete();
    cap_init.delete();
  endtask

  // Busy generator: idle, forced high, or random.
  initial begin
    sha_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (busy_mode)
        1:       sha_busy = 1'b1;
        2:       sha_busy = ($urandom_range(0, 3) == 0);
        default: sha_busy = 1'b0;
      endcase
    end
  end

  // Core model: answers each start with one done pulse after a delay.
  initial begin
    int d;
    int ep;
    sha_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && sha_start) begin
        ep = core_epoch;
        d  = (core_delay != 0) ? core_delay : int'($urandom_range(1, 10));
        repeat (d) @(posedge clk);
        #1;
        if (ep == core_epoch) begin
          sha_done = 1'b1;
          @(posedge clk); #1;
          sha_done = 1'b0;
        end
      end
    end
  end

  // Per-cycle monitor of the core handshake against the expected stream.
  bit           in_flight;
  bit           cur_final;
  bit           exp_md;
  bit           busy_prev;
  logic [511:0] held;
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
      exp_md    = 1'b0;
      busy_prev = 1'b0;
      cur_final = 1'b0;
    end else begin
      check("msg_done", msg_done, exp_md);
      if (exp_md) begin
        check("ready_at_msg_done", byte_ready, 0);
        outstanding--;
      end
      exp_md = 1'b0;
      if (sha_start) begin
        check("start_while_busy", busy_prev, 0);
        check("start_in_flight", in_flight, 0);
        check("start_pending", 512'(exp_q.size() != 0), 1);
        cap_blk.push_back(sha_block);
        cap_init.push_back(sha_init);
        if (exp_q.size() != 0) begin
          check("block", sha_block, exp_q[0].blk);
          check("init", sha_init, exp_q[0].init);
          cur_final = exp_q[0].fin;
          void'(exp_q.pop_front());
        end
        held      = sha_block;
        in_flight = 1'b1;
      end else if (in_flight) begin
        check("block_hold", sha_block, held);
        check("ready_in_wait", byte_ready, 0);
        if (sha_done) begin
          exp_md    = cur_final;
          in_flight = 1'b0;
        end
      end
      busy_prev = sha_busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t          m;
    eq_t          q;
    logic [511:0] b;
    int           n;
    int           len;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    byte_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_sha_block", sha_block, 0);
    check("rst_sha_start", sha_start, 0);
    check("rst_sha_init", sha_init, 0);
    check("rst_msg_done", msg_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_low_after_rst", byte_ready, 0);
    @(negedge clk);
    check("ready_rise", byte_ready, 1);

    // "abc"
    m = {8'h61, 8'h62, 8'h63};
    q = build_blocks(m);
    check("model_abc", q[0].blk, {32'h61626380, 416'h0, 64'h18});
    clear_caps();
    push_msg(m);
    send_msg(m, 2);
    wait_idle();
    check("abc_blocks", 512'(cap_blk.size()), 1);
    if (cap_blk.size() >= 1) begin
      check("abc_block", cap_blk[0], {32'h61626380, 416'h0, 64'h18});
      check("abc_init", cap_init[0], 1);
    end

    // 55 bytes: single block
    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'(i * 3 + 1));
    clear_caps();
    push_msg(m);
    send_msg(m, 1);
    wait_idle();
    check("m55_blocks", 512'(cap_blk.size()), 1);
    if (cap_blk.size() >= 1) begin
      b = cap_blk[0];
      check("m55_pad", b[71:64], 8'h80);
      check("m55_len", b[63:0], 64'h1B8);
    end

    // 56 bytes: length spills into a second block
    m.delete();
    for (int i = 0; i < 56; i++) m.push_back(8'(i + 7));
    q = build_blocks(m);
    check("model_56_count", 512'(q.size()), 2);
    clear_caps();
    push_msg(m);
    send_msg(m, 0);
    wait_idle();
    check("m56_blocks", 512'(cap_blk.size()), 2);
    if (cap_blk.size() >= 2) begin
      b = cap_blk[0];
      check("m56_b1_pad", b[63:56], 8'h80);
      check("m56_b1_zero", b[55:0], 0);
      check("m56_b1_init", cap_init[0], 1);
      check("m56_b2", cap_blk[1], {448'h0, 64'h1C0});
      check("m56_b2_init", cap_init[1], 0);
    end

    // 64 bytes: pure data block then pad block
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    clear_caps();
    push_msg(m);
    send_msg(m, 1);
    wait_idle();
    check("m64_blocks", 512'(cap_blk.size()), 2);
    if (cap_blk.size() >= 2) check("m64_b2", cap_blk[1], {8'h80, 440'h0, 64'h200});

    // Core busy stall
    busy_mode = 1;
    repeat (2) @(negedge clk);
    m = {8'($urandom), 8'($urandom), 8'($urandom)};
    clear_caps();
    push_msg(m);
    send_msg(m, 0);
    repeat (100) @(negedge clk);
    check("no_start_while_busy", 512'(cap_blk.size()), 0);
    @(posedge clk);
    busy_mode = 0;
    @(negedge clk);
    check("start_not_early", sha_start, 0);
    @(negedge clk);
    check("start_after_busy", sha_start, 1);
    wait_idle();

    // Slow core: next byte is held by the producer during WAIT
    core_delay = 100;
    m.delete();
    for (int i = 0; i < 70; i++) m.push_back(8'($urandom));
    clear_caps();
    push_msg(m);
    send_msg(m, 0);
    wait_idle();
    check("slow_blocks", 512'(cap_blk.size()), 2);
    core_delay = 0;

    // Reset during WAIT of block 2 of a 3-block message
    core_delay = 30;
    m.delete();
    for (int i = 0; i < 150; i++) m.push_back(8'($urandom));
    clear_caps();
    push_msg(m);
    fork
      send_msg(m, 0);
      begin
        n = 0;
        while (cap_blk.size() < 2 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check("reached_block2", 512'(cap_blk.size()), 2);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst   = 1'b1;
        abort = 1'b1;
        core_epoch++;
      end
    join
    @(negedge clk);
    check("mid_rst_byte_ready", byte_ready, 0);
    check("mid_rst_sha_block", sha_block, 0);
    check("mid_rst_sha_start", sha_start, 0);
    check("mid_rst_sha_init", sha_init, 0);
    check("mid_rst_msg_done", msg_done, 0);
    exp_q.delete();
    outstanding = 0;
    byte_valid  = 1'b0;
    abort       = 1'b0;
    core_delay  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clear_caps();
    push_msg(m);
    send_msg(m, 1);
    wait_idle();
    check("post_rst_blocks", 512'(cap_blk.size()), 1);
    if (cap_blk.size() >= 1) begin
      b = cap_blk[0];
      check("post_rst_init", cap_init[0], 1);
      check("post_rst_len", b[63:0], 64'd40);
    end

    // Randomised messages, boundary lengths first
    busy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      case (k)
        0: len = 55;
        1: len = 56;
        2: len = 63;
        3: len = 64;
        4: len = 119;
        5: len = 120;
        6: len = 128;
        default: len = int'($urandom_range(1, 200));
      endcase
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      push_msg(m);
      send_msg(m, 3);
    end
    wait_idle();
    busy_mode = 0;
    check("queue_drained", 512'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
